// File: rtl/ro_sample_ctrl_if.sv
// ---------------------------------------------------------------------------
// ro_sample_ctrl_if
// Valid/ready line stream from the ring-oscillator sampling controller to the
// DMA write stage.
//   wr_valid : a packed line is available
//   wr_ready : the consumer accepts the line when wr_valid & wr_ready
//   wr_data  : packed line, sample k at bits [k*CNT_WIDTH +: CNT_WIDTH]
// The master modport is used by the producer (ro_sample_ctrl) and the slave
// modport by the consumer.
// ---------------------------------------------------------------------------
interface ro_sample_ctrl_if #(
  parameter int LINE_WIDTH = 512
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [LINE_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/ro_sample_ctrl.sv
// ---------------------------------------------------------------------------
// ro_sample_ctrl
// Measures a ring-oscillator output as rising-edge counts over back-to-back
// windows of collect_cycles clk cycles, packs the counts into lines of
// SPL = LINE_WIDTH/CNT_WIDTH samples and streams the lines out through a
// 2-entry FIFO. A line that finds the FIFO full is dropped and flagged.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   go              single-cycle start pulse (ignored while busy)
//   num_samples     number of samples to take, latched on accepted go
//   collect_cycles  window length in clk cycles (0 behaves as 1)
//   ro_in           ring-oscillator output, asynchronous to clk
//   wr              line stream (master side of ro_sample_ctrl_if)
//   busy            high while collecting or draining
//   done            high once the run has finished, until the next go
//   overflow        sticky: at least one line was dropped this run
//
// Build option: define RO_SAMPLE_TIMESTAMP_EN to tag each sample with the
// low byte of its sample index in the top 8 bits; the count then occupies
// the remaining CNT_WIDTH-8 bits and saturates accordingly.
// ---------------------------------------------------------------------------
module ro_sample_ctrl #(
  parameter int SIZE_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] num_samples,
  input  logic [SIZE_WIDTH-1:0] collect_cycles,
  input  logic                  ro_in,
  ro_sample_ctrl_if.master      wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int SPL    = LINE_WIDTH / CNT_WIDTH;
  localparam int SLOT_W = (SPL > 1) ? $clog2(SPL) : 1;
  localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(SPL - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
`ifdef RO_SAMPLE_TIMESTAMP_EN
  localparam logic [CNT_WIDTH-1:0] SMP_MAX = {8'h00, {(CNT_WIDTH-8){1'b1}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic                  ro_sync_p0, ro_sync_p1, ro_sync_p2;
  logic                  edge_det;
  logic [SIZE_WIDTH-1:0] n_smp, n_cyc, win_cnt, sample_idx;
  logic [CNT_WIDTH-1:0]  edge_cnt, sample;
  logic [SLOT_W-1:0]     slot;
  logic [LINE_WIDTH-1:0] pack, line_val;
  logic [LINE_WIDTH-1:0] fifo_mem [2];
  logic                  wptr, rptr;
  logic [1:0]            fifo_cnt, fifo_cnt_nxt;
  logic                  accept, win_last, smp_last, line_done;
  logic                  pop, push_ok, drop;

  // Edge counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    if (inc && (v != CNT_MAX)) return v + 1'b1;
    return v;
  endfunction

`ifdef RO_SAMPLE_TIMESTAMP_EN
  function automatic logic [CNT_WIDTH-1:0] pack_sample(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic [7:0] idx);
    if (cnt > SMP_MAX) return {idx, SMP_MAX[CNT_WIDTH-9:0]};
    return {idx, cnt[CNT_WIDTH-9:0]};
  endfunction
`else
  function automatic logic [CNT_WIDTH-1:0] pack_sample(input logic [CNT_WIDTH-1:0] cnt);
    return cnt;
  endfunction
`endif

  // Stage p0..p2: synchronizer, rising edge seen between p1 and p2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_sync_p0 <= 1'b0;
      ro_sync_p1 <= 1'b0;
      ro_sync_p2 <= 1'b0;
    end else begin
      ro_sync_p0 <= ro_in;
      ro_sync_p1 <= ro_sync_p0;
      ro_sync_p2 <= ro_sync_p1;
    end
  end

  assign edge_det  = ro_sync_p1 & ~ro_sync_p2;
  assign accept    = go & ((state == S_IDLE) | (state == S_DONE));
  assign win_last  = (state == S_COLLECT) & (win_cnt == n_cyc);
  assign smp_last  = (sample_idx == (n_smp - SIZE_WIDTH'(1)));
  assign line_done = win_last & ((slot == SLOT_LAST) | smp_last);

`ifdef RO_SAMPLE_TIMESTAMP_EN
  assign sample = pack_sample(sat_inc(edge_cnt, edge_det), sample_idx[7:0]);
`else
  assign sample = pack_sample(sat_inc(edge_cnt, edge_det));
`endif

  // Slots above the current one are already zero because the packer is
  // cleared whenever a line leaves it, so a short final line is zero-padded.
  always_comb begin
    line_val = pack;
    line_val[slot*CNT_WIDTH +: CNT_WIDTH] = sample;
  end

  // A push into a full FIFO still lands if the head pops in the same cycle.
  assign pop          = (fifo_cnt != 2'd0) & wr.wr_ready;
  assign push_ok      = line_done & ((fifo_cnt != 2'd2) | pop);
  assign drop         = line_done & ~push_ok;
  assign fifo_cnt_nxt = fifo_cnt + {1'b0, push_ok} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // DRAIN looks at the next FIFO fill so done rises right after the last pop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_nxt = (num_samples == '0) ? S_DONE : S_COLLECT;
      S_COLLECT:      if (win_last && smp_last) state_nxt = S_DRAIN;
      S_DRAIN:        if (fifo_cnt_nxt == 2'd0) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_COLLECT) | (state == S_DRAIN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_smp      <= '0;
      n_cyc      <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      sample_idx <= '0;
      slot       <= '0;
      pack       <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      n_smp      <= num_samples;
      n_cyc      <= (collect_cycles == '0) ? SIZE_WIDTH'(1) : collect_cycles;
      win_cnt    <= SIZE_WIDTH'(1);
      edge_cnt   <= '0;
      sample_idx <= '0;
      slot       <= '0;
      pack       <= '0;
      overflow   <= 1'b0;
    end else begin
      // The edge seen on a window's last cycle belongs to that window.
      edge_cnt <= win_last ? '0 : sat_inc(edge_cnt, edge_det);
      if (state == S_COLLECT) win_cnt <= win_last ? SIZE_WIDTH'(1) : win_cnt + 1'b1;
      if (win_last) begin
        sample_idx <= sample_idx + 1'b1;
        slot       <= line_done ? '0 : slot + 1'b1;
        pack       <= line_done ? '0 : line_val;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        fifo_mem[wptr] <= line_val;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fifo_cnt <= fifo_cnt_nxt;
    end
  end

  assign wr.wr_valid = (fifo_cnt != 2'd0);
  assign wr.wr_data  = fifo_mem[rptr];

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ro_sample_ctrl
// Directed bench for ro_sample_ctrl. The ring oscillator is modelled as a
// square wave with a period of exactly 4 clk cycles, so a window of W cycles
// (W a multiple of 4) always holds W/4 rising edges. Inputs change 2 time
// units after a rising clk edge; outputs are observed on the falling edge.
// ---------------------------------------------------------------------------
module tb_ro_sample_ctrl;
  localparam int SW  = 32;
  localparam int CW  = 32;
  localparam int LW  = 512;
  localparam int SPL = LW / CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic          ro_in = 1'b0;
  logic          ro_en = 1'b0;
  logic [SW-1:0] num_samples = '0;
  logic [SW-1:0] collect_cycles = '0;
  logic          busy, done, overflow;

  int total = 0;
  int bad = 0;

  logic [LW-1:0] lines[$];
  int            busy_seen = 0;
  int            valid_seen = 0;

  ro_sample_ctrl_if #(.LINE_WIDTH(LW)) wr_if ();

  ro_sample_ctrl #(
    .SIZE_WIDTH (SW),
    .CNT_WIDTH  (CW),
    .LINE_WIDTH (LW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .num_samples    (num_samples),
    .collect_cycles (collect_cycles),
    .ro_in          (ro_in),
    .wr             (wr_if),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Toggle every 20 time units (2 clk) -> one rising edge per 4 clk.
  always begin
    #20;
    ro_in = ro_en ? ~ro_in : 1'b0;
  end

  always @(negedge clk) begin
    if (wr_if.wr_valid && wr_if.wr_ready) lines.push_back(wr_if.wr_data);
    if (busy) busy_seen++;
    if (wr_if.wr_valid) valid_seen++;
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line: first nslots slots hold count v, the rest are zero.
  function automatic logic [LW-1:0] fill(input int nslots, input logic [CW-1:0] v,
                                         input int first_idx);
    logic [LW-1:0] r;
    logic [CW-1:0] s;
    int            idx;
    r = '0;
    for (int k = 0; k < nslots; k++) begin
      idx = first_idx + k;
`ifdef RO_SAMPLE_TIMESTAMP_EN
      s = {idx[7:0], v[CW-9:0]};
`else
      s = v;
`endif
      r[k*CW +: CW] = s;
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] line_at(input int i);
    if (i < lines.size()) return lines[i];
    return '0;
  endfunction

  task automatic pulse_go(input logic [SW-1:0] ns, input logic [SW-1:0] cc);
    @(posedge clk); #2;
    num_samples    = ns;
    collect_cycles = cc;
    go             = 1'b1;
    @(posedge clk); #2;
    go             = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, LW'(done), LW'(1));
  endtask

  initial begin
    int            n;
    int            b, bb, bv;
    logic [LW-1:0] ln;
    logic [CW-1:0] smp;
    wr_if.wr_ready = 1'b0;

    // Reset values
    idle_cycles(2);
    check("rst_valid", LW'(wr_if.wr_valid), LW'(0));
    check("rst_data", wr_if.wr_data, '0);
    check("rst_busy", LW'(busy), LW'(0));
    check("rst_done", LW'(done), LW'(0));
    check("rst_ovf", LW'(overflow), LW'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    // One full line of 16 x 25 edges
    ro_en = 1'b1;
    wr_if.wr_ready = 1'b1;
    idle_cycles(20);
    b = lines.size();
    pulse_go(16, 100);
    @(negedge clk);
    check("t1_busy", LW'(busy), LW'(1));
    check("t1_done_low", LW'(done), LW'(0));
    n = 0;
    while (!wr_if.wr_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t1_valid", LW'(wr_if.wr_valid), LW'(1));
    @(negedge clk);
    check("t1_done_after_pop", LW'(done), LW'(1));
    check("t1_valid_after_pop", LW'(wr_if.wr_valid), LW'(0));
    check("t1_nlines", LW'(lines.size() - b), LW'(1));
    ln = line_at(b);
    for (int k = 0; k < SPL; k++) begin
      smp = ln[k*CW +: CW];
`ifdef RO_SAMPLE_TIMESTAMP_EN
      check($sformatf("t1_smp%0d", k), LW'(smp), LW'({k[7:0], 24'd25}));
`else
      check($sformatf("t1_smp%0d", k), LW'(smp), LW'(25));
`endif
    end
    check("t1_ovf", LW'(overflow), LW'(0));

    // Quiet oscillator, 20 samples -> one full and one partial line
    ro_en = 1'b0;
    idle_cycles(10);
    b = lines.size();
    pulse_go(20, 10);
    @(negedge clk);
    check("t2_done_drop", LW'(done), LW'(0));
    check("t2_busy", LW'(busy), LW'(1));
    wait_done(1000, "t2_done");
    check("t2_nlines", LW'(lines.size() - b), LW'(2));
    check("t2_line0", line_at(b), fill(16, 0, 0));
    check("t2_line1", line_at(b + 1), fill(4, 0, 16));
    check("t2_ovf", LW'(overflow), LW'(0));

    // Partial line with nonzero samples: unfilled slots must be zero
    ro_en = 1'b1;
    idle_cycles(20);
    b = lines.size();
    pulse_go(20, 8);
    wait_done(1000, "t2b_done");
    check("t2b_nlines", LW'(lines.size() - b), LW'(2));
    check("t2b_line0", line_at(b), fill(16, 2, 0));
    check("t2b_line1", line_at(b + 1), fill(4, 2, 16));

    // Zero samples -> straight to done
    bb = busy_seen;
    bv = valid_seen;
    pulse_go(0, 5);
    @(negedge clk);
    check("t3_done", LW'(done), LW'(1));
    check("t3_busy", LW'(busy), LW'(0));
    idle_cycles(10);
    check("t3_busy_seen", LW'(busy_seen - bb), LW'(0));
    check("t3_valid_seen", LW'(valid_seen - bv), LW'(0));

    // Back-pressure: 4 lines, 2 held, 2 dropped
    ro_en = 1'b0;
    idle_cycles(10);
    wr_if.wr_ready = 1'b0;
    b = lines.size();
    pulse_go(64, 1);
    idle_cycles(80);
    check("t4_ovf", LW'(overflow), LW'(1));
    check("t4_valid", LW'(wr_if.wr_valid), LW'(1));
    check("t4_busy", LW'(busy), LW'(1));
    check("t4_no_pop", LW'(lines.size() - b), LW'(0));
    @(posedge clk); #2;
    wr_if.wr_ready = 1'b1;
    wait_done(100, "t4_done");
    check("t4_npop", LW'(lines.size() - b), LW'(2));
    check("t4_ovf_sticky", LW'(overflow), LW'(1));

    // Second go while collecting is ignored
    ro_en = 1'b1;
    idle_cycles(20);
    b = lines.size();
    pulse_go(32, 4);
    @(negedge clk);
    check("t5_ovf_clr", LW'(overflow), LW'(0));
    idle_cycles(40);
    pulse_go(48, 4);
    @(negedge clk);
    check("t5_busy", LW'(busy), LW'(1));
    wait_done(1000, "t5_done");
    check("t5_nlines", LW'(lines.size() - b), LW'(2));
    check("t5_line0", line_at(b), fill(16, 1, 0));

    // Reset mid-collect clears outputs immediately
    wr_if.wr_ready = 1'b0;
    pulse_go(64, 2);
    idle_cycles(40);
    check("t6_pre_valid", LW'(wr_if.wr_valid), LW'(1));
    rst = 1'b1;
    #1;
    check("t6_valid", LW'(wr_if.wr_valid), LW'(0));
    check("t6_data", wr_if.wr_data, '0);
    check("t6_busy", LW'(busy), LW'(0));
    check("t6_done", LW'(done), LW'(0));
    check("t6_ovf", LW'(overflow), LW'(0));
    idle_cycles(3);
    @(posedge clk); #2;
    rst = 1'b0;
    wr_if.wr_ready = 1'b1;
    b = lines.size();
    pulse_go(16, 4);
    wait_done(500, "t6_rerun_done");
    check("t6_rerun_line", line_at(b), fill(16, 1, 0));

`ifdef RO_SAMPLE_TIMESTAMP_EN
    // Timestamp byte wraps at 256
    b = lines.size();
    pulse_go(300, 4);
    wait_done(3000, "ts_done");
    check("ts_nlines", LW'(lines.size() - b), LW'(19));
    ln = line_at(b + 16);
    smp = ln[0 +: CW];
    check("ts_smp256", LW'(smp[31:24]), LW'(8'h00));
    ln = line_at(b + 18);
    smp = ln[11*CW +: CW];
    check("ts_smp299", LW'(smp[31:24]), LW'(8'h2B));
    check("ts_smp299_cnt", LW'(smp[23:0]), LW'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ro_sample_ctrl.md
# ro_sample_ctrl

Sampling controller downstream of the AFU memory map. It consumes `go`, `num_samples` and `collect_cycles` and measures a ring-oscillator output as edge counts over fixed windows of `clk` cycles. It packs the counts into cache lines and presents them on a valid/ready stream to the DMA write stage. It returns `done` to the memory map.

## Interface
- SIZE_WIDTH, 32, width of `num_samples` and `collect_cycles`
- CNT_WIDTH, 32, width of one sample word
- LINE_WIDTH, 512, output line width; must be an integer multiple of CNT_WIDTH; SPL = LINE_WIDTH/CNT_WIDTH samples per line
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- go  in  1  single-cycle start pulse
- num_samples  in  SIZE_WIDTH  samples to take; latched on accepted `go`
- collect_cycles  in  SIZE_WIDTH  window length in clk cycles; latched on accepted `go`; 0 treated as 1
- ro_in  in  1  ring-oscillator output, asynchronous to clk
- wr_valid  out  1  line available
- wr_ready  in  1  DMA write stage accepts line when `wr_valid & wr_ready`
- wr_data  out  LINE_WIDTH  packed line; sample k of the line at bits [k*CNT_WIDTH +: CNT_WIDTH]
- busy  out  1  high in COLLECT and DRAIN
- done  out  1  high in DONE; held until the next accepted `go`
- overflow  out  1  sticky: at least one line was dropped this run

## Operation
- `ro_in` passes through a 3-flop synchronizer; a rising edge is detected between flops 2 and 3. Each detected edge increments the edge counter. The counter saturates at all-ones and never wraps.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE/DONE + `go`: latch the parameters, clear `overflow`, the window counter, the edge counter, the sample index and the packer. If num_samples==0, go to DONE. Otherwise go to COLLECT.
- `go` while in COLLECT or DRAIN is ignored.
- COLLECT: the window counter counts 1..collect_cycles. On the last cycle of a window:
  - the sample is the edge counter plus any edge detected in that same cycle (saturated);
  - the sample is written into the packer slot `sample_idx mod SPL`;
  - the edge counter restarts at 0.
- A line is complete when slot SPL-1 is written, or when the final sample (index num_samples-1) is written. Unfilled slots of the final line are zero.
- A completed line is pushed into a 2-entry line FIFO. If the FIFO is full, the line is dropped, `overflow` is set, and sampling continues on schedule.
- After the final sample, go to DRAIN. DRAIN to DONE when the FIFO is empty.
- `wr_valid` = FIFO non-empty; `wr_data` = FIFO head. The head pops on `wr_valid & wr_ready`. A push and a pop in the same cycle when the FIFO is full succeeds, with no drop.
- Reset at any point returns to IDLE and empties the FIFO. The synchronizer, all counters and the packer clear.

## Timing
- Reset values: wr_valid 0, wr_data 0, busy 0, done 0, overflow 0.
- `go` sampled at edge N: busy=1 from N+1, and window 1 covers cycles N+1..N+collect_cycles.
- Window boundaries are back-to-back, with no dead cycle between windows.
- A completed line is visible on `wr_valid` one cycle after its final sample is captured.
- `ro_in` to counter latency is 3 cycles. Edges in flight at the end of a window count in the next window.
- done=1 in the cycle after the last line pops, or after the last line drops with the FIFO empty.
- With num_samples==0, done=1 at N+1.
- `done` drops the cycle after an accepted `go`.

## Configuration
- `RO_SAMPLE_TIMESTAMP_EN` defined: each sample is {window_index[7:0], count[CNT_WIDTH-9:0]}. The count saturates at 2^(CNT_WIDTH-8)-1. The window index is the sample index mod 256.
- Not defined: the sample is the full CNT_WIDTH count, saturating at 2^CNT_WIDTH-1.

## Test plan
- Defaults; ro_in toggles with a period of 4 clk; collect_cycles=100, num_samples=16, wr_ready=1 -> one line of 16 samples, each 25±1; done=1 one cycle after the pop; overflow=0.
- num_samples=20, collect_cycles=10, ro_in=0 -> two lines; line 2 has samples 0–3 = 0 and slots 4–15 = 0; done asserted.
- num_samples=0 -> done at N+1, no wr_valid, busy never high.
- wr_ready=0, num_samples=64, collect_cycles=1 -> lines 1–2 held in the FIFO; lines 3–4 dropped; overflow=1; after wr_ready=1, exactly 2 lines pop, then done.
- Second `go` mid-COLLECT -> ignored, and the line count is unchanged. Reset mid-COLLECT -> all outputs return to reset values the same cycle.
- `RO_SAMPLE_TIMESTAMP_EN` with 300 samples -> the top byte of sample 256 is 0x00 and of sample 299 is 0x2B.
